// File: rtl/aes_pkg.sv
// AES-128 constants and combinational building blocks shared by the self-test top.
// Round keys and S-boxes are derived from GF(2^8) arithmetic so no hand-typed tables are needed.
package aes_pkg;

    localparam int NR = 10;
    localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] DATA = 128'h00112233445566778899aabbccddeeff;

    typedef logic [127:0] block_t;
    typedef logic [0:10][127:0] rk_t;
    typedef enum logic [1:0] {SRC_DATA, SRC_ENC, SRC_DEC} disp_src_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] x;
        x = gf_inv(b);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic block_t sub_bytes(input block_t s, input logic inverse);
        block_t r;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = inverse ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
        return r;
    endfunction

    // Byte index is row + 4*column; row r rotates left by r columns (right when inverse).
    function automatic block_t shift_rows(input block_t s, input logic inverse);
        block_t r;
        int src;
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++) begin
                src = inverse ? (col + 4 - row) % 4 : (col + row) % 4;
                r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*src) -: 8];
            end
        return r;
    endfunction

    function automatic block_t mix_columns(input block_t s, input logic inverse);
        block_t r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            if (inverse) begin
                r[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
                r[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
                r[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
                r[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
            end else begin
                r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        return r;
    endfunction

    function automatic block_t enc_round(input block_t s, input block_t k, input logic last);
        block_t t;
        t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
        if (!last) t = mix_columns(t, 1'b0);
        return t ^ k;
    endfunction

    function automatic block_t dec_round(input block_t s, input block_t k, input logic last);
        block_t t;
        t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
        if (!last) t = mix_columns(t, 1'b1);
        return t;
    endfunction

    function automatic rk_t key_expansion(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        rk_t rk;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp  = {tmp[23:0], tmp[31:24]};
                tmp  = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])} ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

endpackage

// File: rtl/aes128_selftest_top_if.sv
// Board-facing indicator bundle: pass LED and the three 7-segment digits.
interface aes128_selftest_top_if;
    logic       LED;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;

    modport master (output LED, HEX0, HEX1, HEX2);
    modport slave  (input  LED, HEX0, HEX1, HEX2);
endinterface

// File: rtl/aes_bcd_display.sv
// Converts a byte to three decimal digits (double-dabble) and drives active-low 7-segment codes.
module aes_bcd_display (
    input  logic [7:0] value,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2
);

    logic [11:0] bcd;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // Add-3 correction on any digit >= 5 before each shift keeps every nibble a valid BCD digit.
    always_comb begin
        bcd = '0;
        for (int i = 7; i >= 0; i--) begin
            if (bcd[3:0]  >= 4'd5) bcd[3:0]  = bcd[3:0]  + 4'd3;
            if (bcd[7:4]  >= 4'd5) bcd[7:4]  = bcd[7:4]  + 4'd3;
            if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
            bcd = {bcd[10:0], value[i]};
        end
    end

    assign hex0 = seg7(bcd[3:0]);
    assign hex1 = seg7(bcd[7:4]);
    assign hex2 = seg7(bcd[11:8]);

endmodule

// File: rtl/aes128_selftest_top.sv
// AES-128 encrypt-then-decrypt self test: one round per clock, decimal readout of the state low byte,
// LED lit once decryption recovers the plaintext.
module aes128_selftest_top
    import aes_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    aes128_selftest_top_if.master        disp
);

    localparam rk_t RK = key_expansion(KEY);

    logic [5:0] cnt;
    block_t     enc_state;
    block_t     dec_state;
    block_t     enc_key;
    block_t     dec_key;
    block_t     enc_next;
    block_t     dec_next;
    disp_src_t  disp_src;
    logic [7:0] disp_byte;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;

    // Decrypt step at cnt uses rk[21-cnt], so cnt 12 takes rk9 and cnt 21 takes rk0.
    always_comb begin
        enc_key = RK[0];
        dec_key = RK[0];
        for (int r = 0; r <= NR; r++) begin
            if (cnt == 6'(r))      enc_key = RK[r];
            if (cnt == 6'(21 - r)) dec_key = RK[r];
        end
    end

    always_comb begin
        enc_next = (cnt == 6'd0)  ? (DATA ^ RK[0])
                                  : enc_round(enc_state, enc_key, cnt == 6'(NR));
        dec_next = (cnt == 6'd11) ? (enc_state ^ RK[NR])
                                  : dec_round(dec_state, dec_key, cnt == 6'd21);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            enc_state <= '0;
            dec_state <= '0;
        end else begin
            if (cnt <= 6'd22) cnt <= cnt + 6'd1;
            if (cnt <= 6'd10) enc_state <= enc_next;
            if (cnt >= 6'd11 && cnt <= 6'd21) dec_state <= dec_next;
        end
    end

    always_comb begin
        disp_src = SRC_DATA;
        if (cnt >= 6'd12)     disp_src = SRC_DEC;
        else if (cnt >= 6'd1) disp_src = SRC_ENC;
    end

    always_comb begin
        case (disp_src)
            SRC_ENC: disp_byte = enc_state[7:0];
            SRC_DEC: disp_byte = dec_state[7:0];
            default: disp_byte = DATA[7:0];
        endcase
    end

    aes_bcd_display u_display (
        .value (disp_byte),
        .hex0  (hex0),
        .hex1  (hex1),
        .hex2  (hex2)
    );

    assign disp.HEX0 = hex0;
    assign disp.HEX1 = hex1;
    assign disp.HEX2 = hex2;
    assign disp.LED  = (dec_state == DATA) && (cnt >= 6'd12);

endmodule

// File: tb/tb_aes128_selftest_top.sv
// Directed bench for the AES-128 self-test top: walks the encrypt/decrypt sequence twice,
// the second time after a mid-run reset, against FIPS-197 reference values.
module tb_aes128_selftest_top;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    localparam logic [127:0] PLAIN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] ROUND0 = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] CIPHER = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] DEC0   = 128'h7ad5fda789ef4e272bca100b3d9ff59f;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    aes128_selftest_top_if disp_if ();

    aes128_selftest_top dut (
        .clk   (clk),
        .reset (reset),
        .disp  (disp_if.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_display(input string tag, input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
        check_output({tag, "_hex2"}, 128'(disp_if.HEX2), 128'(e2));
        check_output({tag, "_hex1"}, 128'(disp_if.HEX1), 128'(e1));
        check_output({tag, "_hex0"}, 128'(disp_if.HEX0), 128'(e0));
    endtask

    // Drive reset, let the given number of rising edges pass, then settle before sampling.
    task automatic apply_stimulus(input logic rst, input int edges);
        reset = rst;
        repeat (edges) @(posedge clk);
        #1;
    endtask

    task automatic run_sequence(input string pfx);
        apply_stimulus(1'b0, 1);
        check_output({pfx, "_cnt1"}, 128'(dut.cnt), 128'd1);
        check_output({pfx, "_enc1"}, dut.enc_state, ROUND0);
        check_display({pfx, "_disp240"}, SEG_2, SEG_4, SEG_0);

        apply_stimulus(1'b0, 1);
        check_output({pfx, "_enc2_low"}, 128'(dut.enc_state[7:0]), 128'h e4);
        check_display({pfx, "_disp228"}, SEG_2, SEG_2, SEG_8);

        apply_stimulus(1'b0, 9);
        check_output({pfx, "_cnt11"}, 128'(dut.cnt), 128'd11);
        check_output({pfx, "_cipher"}, dut.enc_state, CIPHER);
        check_display({pfx, "_disp090"}, SEG_0, SEG_9, SEG_0);
        check_output({pfx, "_led11"}, 128'(disp_if.LED), 128'd0);

        apply_stimulus(1'b0, 1);
        check_output({pfx, "_dec12"}, dut.dec_state, DEC0);
        check_display({pfx, "_disp159"}, SEG_1, SEG_5, SEG_9);
        check_output({pfx, "_led12"}, 128'(disp_if.LED), 128'd0);

        apply_stimulus(1'b0, 9);
        check_output({pfx, "_led21"}, 128'(disp_if.LED), 128'd0);

        apply_stimulus(1'b0, 1);
        check_output({pfx, "_cnt22"}, 128'(dut.cnt), 128'd22);
        check_output({pfx, "_plain"}, dut.dec_state, PLAIN);
        check_output({pfx, "_led22"}, 128'(disp_if.LED), 128'd1);
        check_display({pfx, "_disp255"}, SEG_2, SEG_5, SEG_5);

        apply_stimulus(1'b0, 8);
        check_output({pfx, "_cnt_sat"}, 128'(dut.cnt), 128'd23);
        check_output({pfx, "_led_hold"}, 128'(disp_if.LED), 128'd1);
        check_output({pfx, "_enc_hold"}, dut.enc_state, CIPHER);
    endtask

    initial begin
        apply_stimulus(1'b1, 2);
        check_output("rst_cnt", 128'(dut.cnt), 128'd0);
        check_output("rst_enc", dut.enc_state, 128'd0);
        check_output("rst_dec", dut.dec_state, 128'd0);
        check_output("rst_led", 128'(disp_if.LED), 128'd0);
        check_display("rst_disp", SEG_2, SEG_5, SEG_5);

        run_sequence("run1");

        apply_stimulus(1'b1, 1);
        check_output("rst2_cnt", 128'(dut.cnt), 128'd0);
        apply_stimulus(1'b0, 15);
        check_output("mid_cnt15", 128'(dut.cnt), 128'd15);
        check_output("mid_led15", 128'(disp_if.LED), 128'd0);

        apply_stimulus(1'b1, 1);
        check_output("midrst_cnt", 128'(dut.cnt), 128'd0);
        check_output("midrst_led", 128'(disp_if.LED), 128'd0);
        check_display("midrst_disp", SEG_2, SEG_5, SEG_5);

        run_sequence("run2");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
